// File: rtl/clk_sched.sv
// clk_sched: per-channel clock-enable strobes with counted reset release, configured via valid/ready.
// Optional status ports (run, cfg_err) are enabled by defining CLK_SCHED_STATUS_EN.
module clk_sched #(
   parameter int unsigned N_CH     = 4,
   parameter int unsigned DIV_W    = 8,
   parameter int unsigned RST_HOLD = 4,
   localparam int unsigned CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [CH_W-1:0]   cfg_ch,
   input  logic [DIV_W-1:0]  cfg_div,
   input  logic              cfg_en,
   output logic [N_CH-1:0]   clken,
   output logic [N_CH-1:0]   rst_out
`ifdef CLK_SCHED_STATUS_EN
   ,
   output logic [N_CH-1:0]   run,
   output logic              cfg_err
`endif
);

   localparam int unsigned HOLD_W = $clog2(RST_HOLD + 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);

   typedef enum logic [1:0] {ST_OFF, ST_RESET, ST_RUN} ch_state_t;

   ch_state_t          state [N_CH];
   logic [DIV_W-1:0]   cnt   [N_CH];
   logic [DIV_W-1:0]   div_q [N_CH];
   logic [HOLD_W-1:0]  hold  [N_CH];
   logic               accept;
   logic [N_CH-1:0]    sel;

   assign accept = cfg_valid && cfg_ready;

   // Out-of-range channel numbers match no sel bit, so those writes fall through.
   always_comb begin
      sel = '0;
      for (int unsigned i = 0; i < N_CH; i++)
         sel[i] = accept && (32'(cfg_ch) == i);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cfg_ready <= 1'b0;
         clken     <= '0;
         rst_out   <= '1;
`ifdef CLK_SCHED_STATUS_EN
         run       <= '0;
         cfg_err   <= 1'b0;
`endif
         for (int unsigned i = 0; i < N_CH; i++) begin
            state[i] <= ST_OFF;
            cnt[i]   <= '0;
            div_q[i] <= '0;
            hold[i]  <= '0;
         end
      end else begin
         cfg_ready <= !accept;
`ifdef CLK_SCHED_STATUS_EN
         cfg_err   <= accept && !(32'(cfg_ch) < N_CH);
`endif
         for (int unsigned i = 0; i < N_CH; i++) begin
            case (state[i])
               ST_OFF: begin
                  clken[i]   <= 1'b0;
                  rst_out[i] <= 1'b1;
`ifdef CLK_SCHED_STATUS_EN
                  run[i]     <= 1'b0;
`endif
                  if (sel[i] && cfg_en) begin
                     state[i] <= ST_RESET;
                     div_q[i] <= cfg_div;
                     cnt[i]   <= cfg_div;
                     hold[i]  <= '0;
                     clken[i] <= 1'b1;
                  end
               end
               default: begin
                  if (sel[i] && !cfg_en) begin
                     state[i]   <= ST_OFF;
                     clken[i]   <= 1'b0;
                     rst_out[i] <= 1'b1;
`ifdef CLK_SCHED_STATUS_EN
                     run[i]     <= 1'b0;
`endif
                  end else begin
                     if (sel[i])
                        div_q[i] <= cfg_div;
                     // A div update coinciding with expiry reloads straight from the write.
                     if (cnt[i] == '0) begin
                        clken[i] <= 1'b1;
                        cnt[i]   <= sel[i] ? cfg_div : div_q[i];
                     end else begin
                        clken[i] <= 1'b0;
                        cnt[i]   <= cnt[i] - 1'b1;
                     end
                     // clken[i] here is the pulse of the cycle now ending.
                     if (state[i] == ST_RESET && clken[i]) begin
                        if (hold[i] == HOLD_LAST) begin
                           state[i]   <= ST_RUN;
                           rst_out[i] <= 1'b0;
`ifdef CLK_SCHED_STATUS_EN
                           run[i]     <= 1'b1;
`endif
                        end else begin
                           hold[i] <= hold[i] + 1'b1;
                        end
                     end
                  end
               end
            endcase
         end
      end
   end

endmodule
